// File: rtl/icache_set_array.sv
// icache_set_array: SETS x WAYS instruction-cache tag/data array with registered
// lookup, tree-PLRU replacement, fill-to-lookup bypass and a sequenced flush sweep.
// Build option: define ICACHE_PERF_CNT_EN to add saturating hit_cnt/miss_cnt outputs.
module icache_set_array #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_BYTES = 32,
  parameter int unsigned SETS       = 16,
  parameter int unsigned WAYS       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    r_valid,
  input  logic [ADDR_W-1:0]       r_addr,
  output logic                    hit,
  output logic                    miss,
  output logic [8*LINE_BYTES-1:0] data_out,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       w_addr,
  input  logic [8*LINE_BYTES-1:0] data_in,
  input  logic                    flush,
  output logic                    busy
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
`endif
);

  localparam int unsigned LINE_W = 8 * LINE_BYTES;
  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   ctr_q;
  logic [WAYS-1:0]    valid_q [SETS];
  // PLRU tree: bit0 is the root (0 -> left pair), bit1/bit2 pick within the left/right pair.
  logic [2:0]         plru_q  [SETS];
  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [LINE_W-1:0]  line_q  [SETS][WAYS];

  logic               hit_q, hit_d, miss_q, miss_d;
  logic [LINE_W-1:0]  dout_q, dout_d;

  logic [IDX_W-1:0]   r_idx, w_idx;
  logic [TAG_W-1:0]   r_tag, w_tag;
  logic               idle, look_en, fill_en, flush_go, bypass;
  logic               look_hit;
  logic [WAY_W-1:0]   look_way;
  logic [LINE_W-1:0]  look_data;
  logic               fill_match, inv_found;
  logic [WAY_W-1:0]   match_way, inv_way, fill_way;
  logic               unused_off;

  assign r_idx = r_addr[OFF_W +: IDX_W];
  assign w_idx = w_addr[OFF_W +: IDX_W];
  assign r_tag = r_addr[ADDR_W-1 -: TAG_W];
  assign w_tag = w_addr[ADDR_W-1 -: TAG_W];
  assign unused_off = ^{r_addr[OFF_W-1:0], w_addr[OFF_W-1:0]};

  // While sweeping, all requests are ignored; a flush drops a same-cycle fill.
  assign idle     = (state_q == StIdle);
  assign look_en  = idle & r_valid;
  assign fill_en  = idle & we & ~flush;
  assign flush_go = idle & flush;
  assign bypass   = fill_en & look_en & (w_idx == r_idx) & (w_tag == r_tag);

  function automatic logic [WAY_W-1:0] plru_victim(input logic [2:0] p);
    logic [1:0] v;
    if (WAYS == 4)      v = p[0] ? {1'b1, p[2]} : {1'b0, p[1]};
    else if (WAYS == 2) v = {1'b0, p[0]};
    else                v = 2'b00;
    return v[WAY_W-1:0];
  endfunction

  // Point every tree node on the path away from the accessed way.
  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [WAY_W-1:0] way);
    logic [1:0] w2;
    logic [2:0] n;
    w2 = 2'(way);
    n  = p;
    if (WAYS == 4) begin
      n[0] = ~w2[1];
      if (w2[1]) n[2] = ~w2[0];
      else       n[1] = ~w2[0];
    end else if (WAYS == 2) begin
      n[0] = ~w2[0];
    end else begin
      n = 3'b000;
    end
    return n;
  endfunction

  // Tag compare for the lookup set against pre-fill contents.
  always_comb begin
    look_hit  = 1'b0;
    look_way  = '0;
    look_data = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (!look_hit && valid_q[r_idx][w] && (tag_q[r_idx][w] == r_tag)) begin
        look_hit  = 1'b1;
        look_way  = WAY_W'(w);
        look_data = line_q[r_idx][w];
      end
    end
  end

  // Fill way: existing copy of the tag, else lowest invalid way, else PLRU victim.
  always_comb begin
    fill_match = 1'b0;
    match_way  = '0;
    inv_found  = 1'b0;
    inv_way    = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (!fill_match && valid_q[w_idx][w] && (tag_q[w_idx][w] == w_tag)) begin
        fill_match = 1'b1;
        match_way  = WAY_W'(w);
      end
      if (!inv_found && !valid_q[w_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    if (fill_match)     fill_way = match_way;
    else if (inv_found) fill_way = inv_way;
    else                fill_way = plru_victim(plru_q[w_idx]);
  end

  // Next-state of the registered lookup result.
  always_comb begin
    hit_d  = 1'b0;
    miss_d = 1'b0;
    dout_d = '0;
    if (look_en) begin
      if (bypass) begin
        hit_d  = 1'b1;
        dout_d = data_in;
      end else if (look_hit) begin
        hit_d  = 1'b1;
        dout_d = look_data;
      end else begin
        miss_d = 1'b1;
      end
    end
  end

  // Control state: flush FSM, valid/PLRU bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ctr_q   <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      dout_q  <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
      dout_q <= dout_d;
      unique case (state_q)
        StIdle: begin
          if (flush) begin
            state_q <= StFlush;
            ctr_q   <= '0;
          end
        end
        StFlush: begin
          valid_q[ctr_q] <= '0;
          plru_q[ctr_q]  <= '0;
          ctr_q          <= ctr_q + IDX_W'(1);
          if (ctr_q == IDX_W'(SETS - 1)) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      if (look_en && look_hit) plru_q[r_idx] <= plru_touch(plru_q[r_idx], look_way);
      // Placed after the hit update so a fill to the same set wins.
      if (fill_en) begin
        valid_q[w_idx][fill_way] <= 1'b1;
        plru_q[w_idx]            <= plru_touch(plru_q[w_idx], fill_way);
      end
    end
  end

  // Tag and data storage; contents are qualified by valid bits so need no reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[w_idx][fill_way]  <= w_tag;
      line_q[w_idx][fill_way] <= data_in;
    end
  end

  assign hit      = hit_q;
  assign miss     = miss_q;
  assign data_out = dout_q;
  assign busy     = (state_q == StFlush);

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating event counters, cleared by reset and by an accepted flush.
  always_ff @(posedge clk) begin
    if (rst || flush_go) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_d && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_d && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  logic unused_flush_go;
  assign unused_flush_go = flush_go;
`endif

endmodule

// File: tb/tb_icache_set_array.sv
// Bench for icache_set_array (default parameters): directed scenarios followed by a
// randomized phase, all checked against a line-level behavioural cache model.
module tb_icache_set_array;

  localparam int SETS = 16;
  localparam int WAYS = 2;

  logic         clk = 1'b0;
  logic         rst, r_valid, we, flush;
  logic [31:0]  r_addr, w_addr;
  logic [255:0] data_in, data_out;
  logic         hit, miss, busy;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  icache_set_array dut (
    .clk      (clk),
    .rst      (rst),
    .r_valid  (r_valid),
    .r_addr   (r_addr),
    .hit      (hit),
    .miss     (miss),
    .data_out (data_out),
    .we       (we),
    .w_addr   (w_addr),
    .data_in  (data_in),
    .flush    (flush),
    .busy     (busy)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: each set holds WAYS lines; m_vict names the way to evict next.
  bit           m_valid [SETS][WAYS];
  int           m_tag   [SETS][WAYS];
  logic [255:0] m_data  [SETS][WAYS];
  int           m_vict  [SETS];
  int           m_busy;
  logic         e_hit, e_miss;
  logic [255:0] e_data;
  logic [31:0]  e_hcnt, e_mcnt;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      m_vict[s] = 0;
    end
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    int  ri, rt, wi, wt, fw, hw;
    bit  found, byp;
    if (rst) begin
      model_clear();
      m_busy = 0;
      e_hit = 1'b0; e_miss = 1'b0; e_data = '0;
      e_hcnt = 0; e_mcnt = 0;
      return;
    end
    if (m_busy > 0) begin
      m_busy--;
      e_hit = 1'b0; e_miss = 1'b0; e_data = '0;
      return;
    end
    ri = int'((r_addr >> 5) % SETS);
    rt = int'(r_addr >> 9);
    wi = int'((w_addr >> 5) % SETS);
    wt = int'(w_addr >> 9);
    found = 1'b0;
    hw = 0;
    for (int w = 0; w < WAYS; w++)
      if (!found && m_valid[ri][w] && m_tag[ri][w] == rt) begin found = 1'b1; hw = w; end
    byp    = we && !flush && r_valid && ri == wi && rt == wt;
    e_hit  = r_valid && (found || byp);
    e_miss = r_valid && !e_hit;
    e_data = byp ? data_in : ((r_valid && found) ? m_data[ri][hw] : '0);
    if (flush) begin
      model_clear();
      m_busy = SETS;
      e_hcnt = 0; e_mcnt = 0;
      return;
    end
    if (e_hit && e_hcnt != 32'hFFFF_FFFF) e_hcnt++;
    if (e_miss && e_mcnt != 32'hFFFF_FFFF) e_mcnt++;
    fw = -1;
    if (we) begin
      for (int w = 0; w < WAYS; w++)
        if (fw < 0 && m_valid[wi][w] && m_tag[wi][w] == wt) fw = w;
      for (int w = 0; w < WAYS; w++)
        if (fw < 0 && !m_valid[wi][w]) fw = w;
      if (fw < 0) fw = m_vict[wi];
    end
    if (r_valid && found) m_vict[ri] = 1 - hw;
    if (we) begin
      m_valid[wi][fw] = 1'b1;
      m_tag[wi][fw]   = wt;
      m_data[wi][fw]  = data_in;
      m_vict[wi]      = 1 - fw;
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare all outputs to the model.
  task automatic cyc(input string lbl, input bit rs, input bit rv, input logic [31:0] ra,
                     input bit w, input logic [31:0] wa, input logic [255:0] wd, input bit fl);
    rst = rs; r_valid = rv; r_addr = ra; we = w; w_addr = wa; data_in = wd; flush = fl;
    @(posedge clk);
    model_edge();
    #1;
    chk({lbl, ".hit"}, 256'(hit), 256'(e_hit));
    chk({lbl, ".miss"}, 256'(miss), 256'(e_miss));
    chk({lbl, ".data"}, data_out, e_data);
    chk({lbl, ".busy"}, 256'(busy), 256'(m_busy > 0));
`ifdef ICACHE_PERF_CNT_EN
    chk({lbl, ".hcnt"}, 256'(hit_cnt), 256'(e_hcnt));
    chk({lbl, ".mcnt"}, 256'(miss_cnt), 256'(e_mcnt));
`endif
  endtask

  task automatic idle(input string lbl);
    cyc(lbl, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, '0, 1'b0);
  endtask

  task automatic look(input string lbl, input logic [31:0] a);
    cyc(lbl, 1'b0, 1'b1, a, 1'b0, 32'h0, '0, 1'b0);
  endtask

  task automatic fill(input string lbl, input logic [31:0] a, input logic [255:0] d);
    cyc(lbl, 1'b0, 1'b0, 32'h0, 1'b1, a, d, 1'b0);
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [31:0] rnd_addr();
    return (32'($urandom_range(0, 2)) << 9) | (32'($urandom_range(0, 3)) << 5) |
           32'($urandom_range(0, 31));
  endfunction

  localparam logic [255:0] DB = {8{32'hDEADBEEF}};
  localparam logic [255:0] DA = {8{32'hAAAA0000}};
  localparam logic [255:0] DBB = {8{32'hBBBB1111}};
  localparam logic [255:0] DC = {8{32'hCCCC2222}};

  initial begin
    int n;
    m_busy = 0;
    rst = 1'b1; r_valid = 1'b0; we = 1'b0; flush = 1'b0;
    r_addr = '0; w_addr = '0; data_in = '0;
    cyc("rst0", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, '0, 1'b0);
    cyc("rst1", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, '0, 1'b0);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_dout", data_out, '0);

    // Cold lookup misses.
    look("t1", 32'h0);
    chk("t1_miss", 256'(miss), 256'(1));
    chk("t1_hit", 256'(hit), 256'(0));

    // Fill then hit, including another offset within the same line.
    fill("t2f", 32'h0, DB);
    look("t2a", 32'h0);
    chk("t2_hit", 256'(hit), 256'(1));
    chk("t2_data", data_out, DB);
    look("t2b", 32'h1C);
    chk("t2_off_hit", 256'(hit), 256'(1));

    // Replacement in set 0: A recently used, so C evicts B.
    fill("t3a", 32'h000, DA);
    fill("t3b", 32'h200, DBB);
    look("t3ra", 32'h000);
    fill("t3c", 32'h400, DC);
    look("t3lb", 32'h200);
    chk("t3_b_miss", 256'(miss), 256'(1));
    look("t3la", 32'h000);
    chk("t3_a_data", data_out, DA);
    look("t3lc", 32'h400);
    chk("t3_c_data", data_out, DC);

    // Same-cycle fill and lookup of one line bypasses the array.
    cyc("t4", 1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 256'h1, 1'b0);
    chk("t4_hit", 256'(hit), 256'(1));
    chk("t4_data", data_out, 256'h1);

    // Flush sweep: busy for SETS cycles, lookups suppressed, everything invalid after.
    for (int i = 0; i < 4; i++) fill("t5f", 32'(i) << 5, rnd_line());
    cyc("t5fl", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, '0, 1'b1);
    n = 1;
    for (int i = 0; i < 40 && busy; i++) begin
      cyc("t5busy", 1'b0, 1'b1, 32'h20, 1'b1, 32'h60, DB, 1'b1);
      if (busy) n++;
    end
    chk("t5_busylen", 256'(n), 256'(SETS));
    for (int i = 0; i < 4; i++) begin
      look("t5l", 32'(i) << 5);
      chk("t5_miss", 256'(miss), 256'(1));
    end

    // Reset in the middle of a sweep.
    fill("t5rf", 32'h0, DB);
    cyc("t5rfl", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, '0, 1'b1);
    for (int i = 0; i < 4; i++) idle("t5rw");
    cyc("t5rst", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, '0, 1'b0);
    chk("t5_rst_busy", 256'(busy), 256'(0));
    look("t5rl", 32'h0);
    chk("t5_rst_miss", 256'(miss), 256'(1));

`ifdef ICACHE_PERF_CNT_EN
    // Counter scenario from a freshly flushed array.
    cyc("t6fl", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, '0, 1'b1);
    chk("t6_clr_h", 256'(hit_cnt), 256'(0));
    for (int i = 0; i < 40 && busy; i++) idle("t6w");
    fill("t6f", 32'h80, DB);
    look("t6h", 32'h80); look("t6h", 32'h80); look("t6h", 32'h84);
    look("t6m", 32'h280); look("t6m", 32'hA0);
    chk("t6_hcnt", 256'(hit_cnt), 256'(3));
    chk("t6_mcnt", 256'(miss_cnt), 256'(2));
    cyc("t6fl2", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, '0, 1'b1);
    chk("t6_zero_h", 256'(hit_cnt), 256'(0));
    chk("t6_zero_m", 256'(miss_cnt), 256'(0));
`endif

    // Randomized traffic over a small address pool to exercise hits and evictions.
    for (int i = 0; i < 3000; i++) begin
      cyc("rnd", ($urandom_range(0, 499) == 0), $urandom_range(0, 1) == 1, rnd_addr(),
          $urandom_range(0, 2) == 0, rnd_addr(), rnd_line(), ($urandom_range(0, 149) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
